// File: rtl/clock_pkg.sv
// Shared state encodings, edit-field codes and BCD digit limits for the clock set/alarm controller.
// Pure declarations and helpers; no timing or flow control.
package clock_pkg;

    typedef enum logic [1:0] {
        IDLE,
        EDIT_TIME,
        EDIT_ALARM,
        COMMIT
    } edit_state_t;

    typedef enum logic [1:0] {
        R_IDLE,
        R_RING,
        R_SNOOZE
    } ring_state_t;

    localparam logic [1:0] FLD_H1 = 2'd0;
    localparam logic [1:0] FLD_H0 = 2'd1;
    localparam logic [1:0] FLD_M1 = 2'd2;
    localparam logic [1:0] FLD_M0 = 2'd3;

    localparam logic [3:0] H1_MAX    = 4'd2;
    localparam logic [3:0] H0_MAX    = 4'd9;
    localparam logic [3:0] H0_MAX_20 = 4'd3;
    localparam logic [3:0] M1_MAX    = 4'd5;
    localparam logic [3:0] M0_MAX    = 4'd9;

    function automatic logic [3:0] digit_inc(input logic [3:0] d, input logic [3:0] max);
        return (d >= max) ? 4'd0 : d + 4'd1;
    endfunction

    function automatic logic [5:0] bcd_to_bin(input logic [3:0] tens, input logic [3:0] ones);
        return 6'(tens) * 6'd10 + 6'(ones);
    endfunction

endpackage

// File: rtl/bin2bcd_2dig.sv
// Binary 0..59 to two BCD digits, purely combinational (zero latency).
// No flow control: output follows input every cycle.
module bin2bcd_2dig (
    input  logic [5:0] bin,
    output logic [3:0] tens,
    output logic [3:0] ones
);

    assign tens = 4'(bin / 6'd10);
    assign ones = 4'(bin % 6'd10);

endmodule

// File: rtl/clock_set_alarm_ctrl.sv
// Button-driven time/alarm editor plus alarm ring/snooze sequencer; all outputs registered state, 1-cycle response.
// Buttons are single-cycle pulses with no backpressure; ok/snooze are owned by the ring FSM while it is active.
module clock_set_alarm_ctrl
    import clock_pkg::*;
#(
    parameter int RING_SECONDS   = 60,
    parameter int SNOOZE_SECONDS = 300,
    parameter int EDIT_TIMEOUT   = 30
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic       btn_mode,
    input  logic       btn_next,
    input  logic       btn_inc,
    input  logic       btn_ok,
    input  logic       btn_snooze,
    input  logic [5:0] cur_hour,
    input  logic [5:0] cur_minute,
    input  logic [5:0] cur_second,
    output logic [3:0] hour1,
    output logic [3:0] hour0,
    output logic [3:0] minute1,
    output logic [3:0] minute0,
    output logic       set_time,
    output logic       edit_active,
    output logic       edit_alarm,
    output logic [1:0] edit_field,
    output logic [5:0] alarm_hour,
    output logic [5:0] alarm_minute,
    output logic       alarm_en,
    output logic       ring,
    output logic       snoozed
);

    localparam int CNT_MAX = (RING_SECONDS > SNOOZE_SECONDS) ? RING_SECONDS : SNOOZE_SECONDS;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int IDL_W   = $clog2(EDIT_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] RING_LAST = CNT_W'(RING_SECONDS - 1);
    localparam logic [CNT_W-1:0] SNOOZE_LD = CNT_W'(SNOOZE_SECONDS);
    localparam logic [IDL_W-1:0] EDIT_LAST = IDL_W'(EDIT_TIMEOUT - 1);

    edit_state_t      edit_q, edit_d;
    ring_state_t      ring_q, ring_d;
    logic [3:0]       h1_q, h1_d, h0_q, h0_d, m1_q, m1_d, m0_q, m0_d;
    logic [1:0]       fld_q, fld_d;
    logic [IDL_W-1:0] idle_q, idle_d;
    logic [5:0]       al_hour_q, al_hour_d, al_min_q, al_min_d;
    logic             al_en_q, al_en_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             match, match_q;
    logic             ok_edit, snz_edit, btn_any;
    logic [5:0]       src_hour, src_min;
    logic [3:0]       ld_h1, ld_h0, ld_m1, ld_m0;

    // Digits load from the running time when entering from IDLE, otherwise from the stored alarm.
    assign src_hour = (edit_q == IDLE) ? cur_hour   : al_hour_q;
    assign src_min  = (edit_q == IDLE) ? cur_minute : al_min_q;

    bin2bcd_2dig u_hour_bcd (.bin(src_hour), .tens(ld_h1), .ones(ld_h0));
    bin2bcd_2dig u_min_bcd  (.bin(src_min),  .tens(ld_m1), .ones(ld_m0));

    assign btn_any  = btn_mode | btn_next | btn_inc | btn_ok | btn_snooze;
    assign ok_edit  = btn_ok && (ring_q == R_IDLE);
    assign snz_edit = btn_snooze && (ring_q == R_IDLE);
    assign match    = al_en_q && (cur_hour == al_hour_q) && (cur_minute == al_min_q)
                      && (cur_second == 6'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            edit_q    <= IDLE;
            ring_q    <= R_IDLE;
            h1_q      <= '0;
            h0_q      <= '0;
            m1_q      <= '0;
            m0_q      <= '0;
            fld_q     <= FLD_H1;
            idle_q    <= '0;
            al_hour_q <= '0;
            al_min_q  <= '0;
            al_en_q   <= 1'b0;
            cnt_q     <= '0;
            match_q   <= 1'b0;
        end else begin
            edit_q    <= edit_d;
            ring_q    <= ring_d;
            h1_q      <= h1_d;
            h0_q      <= h0_d;
            m1_q      <= m1_d;
            m0_q      <= m0_d;
            fld_q     <= fld_d;
            idle_q    <= idle_d;
            al_hour_q <= al_hour_d;
            al_min_q  <= al_min_d;
            al_en_q   <= al_en_d;
            cnt_q     <= cnt_d;
            match_q   <= match;
        end
    end

    always_comb begin
        edit_d    = edit_q;
        h1_d      = h1_q;
        h0_d      = h0_q;
        m1_d      = m1_q;
        m0_d      = m0_q;
        fld_d     = fld_q;
        idle_d    = idle_q;
        al_hour_d = al_hour_q;
        al_min_d  = al_min_q;
        al_en_d   = al_en_q;
        case (edit_q)
            IDLE: begin
                if (btn_mode) begin
                    edit_d = EDIT_TIME;
                    {h1_d, h0_d, m1_d, m0_d} = {ld_h1, ld_h0, ld_m1, ld_m0};
                    fld_d  = FLD_H1;
                    idle_d = '0;
                end
            end
            EDIT_TIME, EDIT_ALARM: begin
                if (btn_any) begin
                    idle_d = '0;
                end else if (tick_1hz) begin
                    idle_d = idle_q + 1'b1;
                end
                if (btn_mode) begin
                    if (edit_q == EDIT_TIME) begin
                        edit_d = EDIT_ALARM;
                        {h1_d, h0_d, m1_d, m0_d} = {ld_h1, ld_h0, ld_m1, ld_m0};
                        fld_d = FLD_H1;
                    end else begin
                        edit_d = IDLE;
                    end
                end else if (ok_edit) begin
                    if (edit_q == EDIT_TIME) begin
                        edit_d = COMMIT;
                    end else begin
                        al_hour_d = bcd_to_bin(h1_q, h0_q);
                        al_min_d  = bcd_to_bin(m1_q, m0_q);
                        al_en_d   = 1'b1;
                        edit_d    = IDLE;
                    end
                end else if (snz_edit && edit_q == EDIT_ALARM) begin
                    al_en_d = 1'b0;
                    edit_d  = IDLE;
                end else if (btn_next) begin
                    fld_d = fld_q + 2'd1;
                end else if (btn_inc) begin
                    case (fld_q)
                        FLD_H1: begin
                            h1_d = digit_inc(h1_q, H1_MAX);
                            if (h1_d == H1_MAX && h0_q > H0_MAX_20) h0_d = H0_MAX_20;
                        end
                        FLD_H0:  h0_d = digit_inc(h0_q, (h1_q == H1_MAX) ? H0_MAX_20 : H0_MAX);
                        FLD_M1:  m1_d = digit_inc(m1_q, M1_MAX);
                        default: m0_d = digit_inc(m0_q, M0_MAX);
                    endcase
                end else if (!btn_any && tick_1hz && idle_q == EDIT_LAST) begin
                    edit_d = IDLE;
                end
            end
            default: edit_d = IDLE;
        endcase
    end

    // Only a rising registered match arms the ring, so one alarm minute rings at most once.
    always_comb begin
        ring_d = ring_q;
        cnt_d  = cnt_q;
        case (ring_q)
            R_IDLE: begin
                if (match && !match_q) begin
                    ring_d = R_RING;
                    cnt_d  = '0;
                end
            end
            R_RING: begin
                if (!al_en_q || btn_ok) begin
                    ring_d = R_IDLE;
                end else if (btn_snooze) begin
                    ring_d = R_SNOOZE;
                    cnt_d  = SNOOZE_LD;
                end else if (tick_1hz) begin
                    if (cnt_q == RING_LAST) ring_d = R_IDLE;
                    else                    cnt_d  = cnt_q + 1'b1;
                end
            end
            R_SNOOZE: begin
                if (!al_en_q || btn_ok) begin
                    ring_d = R_IDLE;
                end else if (tick_1hz) begin
                    if (cnt_q <= CNT_W'(1)) begin
                        ring_d = R_RING;
                        cnt_d  = '0;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            default: ring_d = R_IDLE;
        endcase
    end

    assign hour1        = h1_q;
    assign hour0        = h0_q;
    assign minute1      = m1_q;
    assign minute0      = m0_q;
    assign set_time     = (edit_q == COMMIT);
    assign edit_active  = (edit_q == EDIT_TIME) || (edit_q == EDIT_ALARM);
    assign edit_alarm   = (edit_q == EDIT_ALARM);
    assign edit_field   = fld_q;
    assign alarm_hour   = al_hour_q;
    assign alarm_minute = al_min_q;
    assign alarm_en     = al_en_q;
    assign ring         = (ring_q == R_RING);
    assign snoozed      = (ring_q == R_SNOOZE);

endmodule

// File: tb/tb_clock_set_alarm_ctrl.sv
// Directed scenarios plus random button/tick traffic, checked against a seconds-level behavioural model.
module tb_clock_set_alarm_ctrl;

    localparam int RING_S   = 60;
    localparam int SNOOZE_S = 300;
    localparam int EDIT_TO  = 30;
    localparam int B_MODE = 0, B_NEXT = 1, B_INC = 2, B_OK = 3, B_SNZ = 4;

    logic       clk = 1'b0;
    logic       rst, tick_1hz;
    logic       btn_mode, btn_next, btn_inc, btn_ok, btn_snooze;
    logic [5:0] cur_hour, cur_minute, cur_second;
    logic [3:0] hour1, hour0, minute1, minute0;
    logic       set_time, edit_active, edit_alarm;
    logic [1:0] edit_field;
    logic [5:0] alarm_hour, alarm_minute;
    logic       alarm_en, ring, snoozed;

    int n_chk = 0;
    int n_fail = 0;
    int ch, cm, cs;

    // Model: edit mode 0=none 1=time 2=alarm; ring mode 0=quiet 1=ringing 2=snoozing
    int em, fld, quiet, al_h, al_m, rmode, rsec, zleft;
    int dig[4];
    bit committing, al_en_m, prev_match;

    assign cur_hour   = 6'(ch);
    assign cur_minute = 6'(cm);
    assign cur_second = 6'(cs);

    always #5 clk = ~clk;

    clock_set_alarm_ctrl dut (
        .clk(clk), .rst(rst), .tick_1hz(tick_1hz),
        .btn_mode(btn_mode), .btn_next(btn_next), .btn_inc(btn_inc),
        .btn_ok(btn_ok), .btn_snooze(btn_snooze),
        .cur_hour(cur_hour), .cur_minute(cur_minute), .cur_second(cur_second),
        .hour1(hour1), .hour0(hour0), .minute1(minute1), .minute0(minute0),
        .set_time(set_time), .edit_active(edit_active), .edit_alarm(edit_alarm),
        .edit_field(edit_field), .alarm_hour(alarm_hour), .alarm_minute(alarm_minute),
        .alarm_en(alarm_en), .ring(ring), .snoozed(snoozed)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        em = 0; fld = 0; quiet = 0; al_h = 0; al_m = 0; rmode = 0; rsec = 0; zleft = 0;
        committing = 0; al_en_m = 0; prev_match = 0;
        for (int i = 0; i < 4; i++) dig[i] = 0;
    endtask

    task automatic load_digits(input int h, input int m);
        dig[0] = h / 10; dig[1] = h % 10; dig[2] = m / 10; dig[3] = m % 10;
    endtask

    task automatic model_step();
        bit m_now, trig, busy, ok, sz, any, old_en;
        int lim;
        m_now  = al_en_m && ch == al_h && cm == al_m && cs == 0;
        trig   = m_now && !prev_match;
        busy   = rmode != 0;
        ok     = btn_ok && !busy;
        sz     = btn_snooze && !busy;
        any    = btn_mode || btn_next || btn_inc || btn_ok || btn_snooze;
        old_en = al_en_m;
        prev_match = m_now;
        if (rmode == 0) begin
            if (trig) begin rmode = 1; rsec = 0; end
        end else if (!old_en || btn_ok) begin
            rmode = 0;
        end else if (rmode == 1) begin
            if (btn_snooze) begin
                rmode = 2; zleft = SNOOZE_S;
            end else if (tick_1hz) begin
                rsec++;
                if (rsec >= RING_S) rmode = 0;
            end
        end else if (tick_1hz) begin
            zleft--;
            if (zleft == 0) begin rmode = 1; rsec = 0; end
        end
        if (committing) begin
            committing = 0;
        end else if (em == 0) begin
            if (btn_mode) begin em = 1; load_digits(ch, cm); fld = 0; quiet = 0; end
        end else begin
            if (any) quiet = 0;
            else if (tick_1hz) quiet++;
            if (btn_mode) begin
                if (em == 1) begin em = 2; load_digits(al_h, al_m); fld = 0; end
                else em = 0;
            end else if (ok) begin
                if (em == 1) begin em = 0; committing = 1; end
                else begin
                    al_h = dig[0] * 10 + dig[1]; al_m = dig[2] * 10 + dig[3];
                    al_en_m = 1; em = 0;
                end
            end else if (sz && em == 2) begin
                al_en_m = 0; em = 0;
            end else if (btn_next) begin
                fld = (fld + 1) % 4;
            end else if (btn_inc) begin
                case (fld)
                    0: lim = 2;
                    1: lim = (dig[0] == 2) ? 3 : 9;
                    2: lim = 5;
                    default: lim = 9;
                endcase
                dig[fld] = (dig[fld] + 1) % (lim + 1);
                if (fld == 0 && dig[0] == 2 && dig[1] > 3) dig[1] = 3;
            end else if (!any && quiet >= EDIT_TO) begin
                em = 0;
            end
        end
    endtask

    task automatic compare_all();
        chk("hour1", hour1, dig[0]);
        chk("hour0", hour0, dig[1]);
        chk("minute1", minute1, dig[2]);
        chk("minute0", minute0, dig[3]);
        chk("set_time", set_time, committing);
        chk("edit_active", edit_active, em != 0);
        chk("edit_alarm", edit_alarm, em == 2);
        chk("edit_field", edit_field, fld);
        chk("alarm_hour", alarm_hour, al_h);
        chk("alarm_minute", alarm_minute, al_m);
        chk("alarm_en", alarm_en, al_en_m);
        chk("ring", ring, rmode == 1);
        chk("snoozed", snoozed, rmode == 2);
    endtask

    task automatic adv_time();
        cs++;
        if (cs == 60) begin
            cs = 0; cm++;
            if (cm == 60) begin cm = 0; ch = (ch + 1) % 24; end
        end
    endtask

    task automatic clear_inputs();
        tick_1hz = 0; btn_mode = 0; btn_next = 0; btn_inc = 0; btn_ok = 0; btn_snooze = 0;
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        if (tick_1hz) adv_time();
        compare_all();
        clear_inputs();
    endtask

    task automatic press(input int b);
        case (b)
            B_MODE:  btn_mode = 1;
            B_NEXT:  btn_next = 1;
            B_INC:   btn_inc = 1;
            B_OK:    btn_ok = 1;
            default: btn_snooze = 1;
        endcase
        step();
    endtask

    task automatic sec();
        tick_1hz = 1;
        step();
        step();
    endtask

    task automatic set_alarm(input int h, input int m);
        press(B_MODE);
        press(B_MODE);
        repeat (h / 10) press(B_INC);
        press(B_NEXT);
        repeat (h % 10) press(B_INC);
        press(B_NEXT);
        repeat (m / 10) press(B_INC);
        press(B_NEXT);
        repeat (m % 10) press(B_INC);
        press(B_OK);
    endtask

    task automatic do_reset();
        rst = 1;
        clear_inputs();
        #2;
        model_reset();
        compare_all();
        @(posedge clk);
        #1;
        rst = 0;
    endtask

    initial begin
        int t;
        ch = 0; cm = 0; cs = 0;
        do_reset();

        // 1: H1 1->2 with H0 already 3, then commit
        ch = 13; cm = 45; cs = 10;
        press(B_MODE);
        chk("t1_load_h1", hour1, 1);
        chk("t1_load_h0", hour0, 3);
        press(B_INC);
        chk("t1_inc_h1", hour1, 2);
        chk("t1_clamp_h0", hour0, 3);
        press(B_OK);
        chk("t1_set_pulse", set_time, 1);
        step();
        chk("t1_set_done", set_time, 0);
        chk("t1_digits", {hour1, hour0, minute1, minute0}, 16'h2345);

        // 2: digit wraps and field rotation
        ch = 23; cm = 55;
        press(B_MODE);
        press(B_NEXT);
        press(B_INC);
        chk("t2_h0_wrap", hour0, 0);
        press(B_NEXT);
        chk("t2_field_m1", edit_field, 2);
        press(B_INC);
        chk("t2_m1_wrap", minute1, 0);
        press(B_NEXT);
        press(B_NEXT);
        chk("t2_field_back", edit_field, 0);
        press(B_MODE);
        press(B_MODE);
        chk("t2_exit", edit_active, 0);

        // 3: alarm 07:30 rings for 60 ticks, then no retrigger
        set_alarm(7, 30);
        chk("t3_al_h", alarm_hour, 7);
        chk("t3_al_m", alarm_minute, 30);
        chk("t3_al_en", alarm_en, 1);
        ch = 7; cm = 29; cs = 59;
        tick_1hz = 1;
        step();
        chk("t3_pre_ring", ring, 0);
        step();
        chk("t3_ring_on", ring, 1);
        repeat (RING_S - 1) sec();
        chk("t3_ring_59", ring, 1);
        sec();
        chk("t3_ring_off", ring, 0);
        repeat (2) sec();
        chk("t3_no_retrig", ring, 0);

        // 4: snooze for 300 ticks, re-ring, ok+snooze dismisses
        ch = 7; cm = 29; cs = 59;
        tick_1hz = 1;
        step();
        step();
        chk("t4_ring", ring, 1);
        press(B_SNZ);
        chk("t4_snoozed", snoozed, 1);
        chk("t4_ring_off", ring, 0);
        repeat (SNOOZE_S - 1) sec();
        chk("t4_still_snz", snoozed, 1);
        sec();
        chk("t4_rering", ring, 1);
        btn_ok = 1;
        btn_snooze = 1;
        step();
        chk("t4_ok_wins_ring", ring, 0);
        chk("t4_ok_wins_snz", snoozed, 0);

        // 5: edit timeout, then reset mid-edit
        press(B_MODE);
        repeat (EDIT_TO - 1) sec();
        chk("t5_before_to", edit_active, 1);
        sec();
        chk("t5_timeout", edit_active, 0);
        press(B_MODE);
        press(B_INC);
        do_reset();
        chk("t5_rst_edit", edit_active, 0);
        chk("t5_rst_digits", {hour1, hour0, minute1, minute0}, 0);

        // 6: ring during EDIT_TIME; ok only dismisses the ring
        set_alarm(7, 30);
        ch = 7; cm = 29; cs = 58;
        press(B_MODE);
        tick_1hz = 1;
        step();
        tick_1hz = 1;
        step();
        step();
        chk("t6_ring", ring, 1);
        chk("t6_editing", edit_active, 1);
        press(B_OK);
        chk("t6_ring_off", ring, 0);
        chk("t6_still_edit", edit_active, 1);
        chk("t6_no_set", set_time, 0);
        step();
        chk("t6_no_set2", set_time, 0);
        press(B_MODE);
        press(B_MODE);

        // Random traffic with occasional jumps to just before the alarm time
        for (int i = 0; i < 3000; i++) begin
            tick_1hz   = ($urandom_range(3) == 0);
            btn_mode   = ($urandom_range(39) == 0);
            btn_next   = ($urandom_range(11) == 0);
            btn_inc    = ($urandom_range(7) == 0);
            btn_ok     = ($urandom_range(29) == 0);
            btn_snooze = ($urandom_range(29) == 0);
            if ($urandom_range(149) == 0) begin
                t  = (al_h * 3600 + al_m * 60 + 86400 - 1 - $urandom_range(2)) % 86400;
                ch = t / 3600; cm = (t / 60) % 60; cs = t % 60;
            end
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
